// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - pipelined data memory with counted load stall, big-endian lanes, boot port
// Optional: define DATA_MEM_PERF_EN to add perf_stall_cycles / perf_loads counters.
module data_mem_pipe #(
  parameter int DM_DATAWIDTH    = 32,
  parameter int DM_BYTEENAWIDTH = DM_DATAWIDTH / 8,
  parameter int DM_ADDRESSWIDTH = 10,
  parameter int DM_SIZE         = 256,
  parameter int RD_LATENCY      = 1,
  parameter int BOOT_ADDRWIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  output logic                      stalled,
  input  logic [31:0]               d_address,
  input  logic [3:0]                op,
  input  logic [DM_DATAWIDTH-1:0]   d_writedata,
  output logic [DM_DATAWIDTH-1:0]   d_loadresult,
  output logic                      misaligned,
  input  logic [BOOT_ADDRWIDTH-1:0] boot_daddr,
  input  logic [DM_DATAWIDTH-1:0]   boot_ddata,
  input  logic                      boot_dwe
`ifdef DATA_MEM_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_loads
`endif
);

  localparam int LB = $clog2(DM_BYTEENAWIDTH);
  localparam int IW = $clog2(DM_SIZE);
  localparam int CW = 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Access size in bytes; the dword encoding degrades to a word on 32-bit memory.
  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      2'b11:   return 1;
      2'b01:   return 2;
      2'b10:   return (DM_DATAWIDTH == 64) ? 8 : 4;
      default: return 4;
    endcase
  endfunction

  logic [DM_DATAWIDTH-1:0] mem [DM_SIZE];

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DM_DATAWIDTH-1:0] rd_reg;
  logic [LB-1:0]     lat_a;
  logic [2:0]        lat_op;
  logic              lat_mis;
  logic              accept, capture;

  logic [IW-1:0]     addr_idx, boot_idx;
  int                st_off, st_n, st_sh;
  logic [DM_DATAWIDTH-1:0] wd_sh, st_mask, wr_word, rd_word;
  logic              is_half, is_word, is_dword, we;

  int                ld_off, ld_n, ld_sh;
  logic [DM_DATAWIDTH-1:0] ld_raw, ld_mask;
  logic              ld_neg;

  logic              unused_addr;
  assign unused_addr = ^d_address[30:DM_ADDRESSWIDTH];

  // Upper address bits beyond the array are dropped, so accesses wrap.
  assign addr_idx = IW'(d_address[DM_ADDRESSWIDTH-1:LB]);
  assign boot_idx = IW'(boot_daddr);

  assign st_n     = size_bytes(op[1:0]);
  assign is_half  = (st_n == 2);
  assign is_word  = (st_n == 4);
  assign is_dword = (st_n == 8);
  assign misaligned = en & ((is_half & d_address[0]) |
                            (is_word & (|d_address[1:0])) |
                            (is_dword & (|d_address[2:0])));
  assign we = en & op[3] & ~d_address[31] & ~misaligned;

  // Store merge: lane 0 is the most significant byte, so data shifts up from the LSB end.
  always_comb begin
    st_off = int'(d_address[LB-1:0]);
    st_sh  = (DM_BYTEENAWIDTH - st_off - st_n) * 8;
    if (st_sh < 0) st_sh = 0;
    wd_sh   = d_writedata << st_sh;
    st_mask = (~({DM_DATAWIDTH{1'b1}} << (st_n * 8))) << st_sh;
    wr_word = (mem[addr_idx] & ~st_mask) | (wd_sh & st_mask);
  end

  // A boot write landing on the word being captured is forwarded so the load sees new data.
  assign rd_word = (boot_dwe && (boot_idx == addr_idx)) ? boot_ddata : mem[addr_idx];

  // Memory array: boot write is applied last so it wins over a same-word store.
  always_ff @(posedge clk) begin
    if (we) mem[addr_idx] <= wr_word;
    if (boot_dwe) mem[boot_idx] <= boot_ddata;
  end

  // Load FSM state, counter, latched request and read register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_reg  <= '0;
      lat_a   <= '0;
      lat_op  <= '0;
      lat_mis <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_a   <= d_address[LB-1:0];
        lat_op  <= op[2:0];
        lat_mis <= misaligned;
      end
      if (capture) rd_reg <= rd_word;
    end
  end

  // Next state: the request cycle stalls too, so WAIT lasts RD_LATENCY-1 cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stalled   = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (en && !op[3]) begin
          stalled = 1'b1;
          accept  = 1'b1;
          cnt_nxt = CW'(RD_LATENCY - 1);
          if (RD_LATENCY == 1) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!en) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          stalled = 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt_nxt == '0) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load formatting: shift selected lanes to the bottom, then zero- or sign-extend.
  always_comb begin
    ld_off  = int'(lat_a);
    ld_n    = size_bytes(lat_op[1:0]);
    ld_sh   = (DM_BYTEENAWIDTH - ld_off - ld_n) * 8;
    if (ld_sh < 0) ld_sh = 0;
    ld_raw  = rd_reg >> ld_sh;
    ld_mask = ~({DM_DATAWIDTH{1'b1}} << (ld_n * 8));
    ld_neg  = lat_op[2] & (|(ld_raw & ld_mask & ~(ld_mask >> 1)));
    d_loadresult = lat_mis ? '0 : ((ld_raw & ld_mask) | (ld_neg ? ~ld_mask : '0));
  end

`ifdef DATA_MEM_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cycles <= '0;
      perf_loads        <= '0;
    end else begin
      if (stalled && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if ((state == DONE) && (perf_loads != '1)) perf_loads <= perf_loads + 1'b1;
    end
  end
`endif

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
Parametrised next-generation data memory for the soft processor pipeline. Supports 32- or 64-bit words, a configurable multi-cycle load latency with a counted stall FSM, misalignment detection, and an I/O-region store suppression. A boot port writes memory contents before run. Byte lanes are big-endian: byte 0 is in the most significant lane.

Parameters:
DM_DATAWIDTH, 32, word width; legal values are 32 or 64.
DM_BYTEENAWIDTH, DM_DATAWIDTH/8, byte-enable width.
DM_ADDRESSWIDTH, 10, byte-address bits decoded; word index = d_address[DM_ADDRESSWIDTH-1:log2(DM_BYTEENAWIDTH)].
DM_SIZE, 256, number of words.
RD_LATENCY, 1, number of stall cycles per load; legal range 1..4.
BOOT_ADDRWIDTH, 8, boot port word-address width.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
en  in  1  pipeline stage enable; request valid
stalled  out  1  pipeline stall request
d_address  in  32  byte address; bit 31 = I/O region
op  in  4  {store, sign, size1, size0}; size 11=byte, 01=half, 00=word, 10=dword (64-bit only, otherwise treated as word)
d_writedata  in  DM_DATAWIDTH  store data, least-significant aligned
d_loadresult  out  DM_DATAWIDTH  aligned, sign- or zero-extended load data
misaligned  out  1  access-alignment fault
boot_daddr  in  BOOT_ADDRWIDTH  boot word address
boot_ddata  in  DM_DATAWIDTH  boot write data
boot_dwe  in  1  boot write enable

Behaviour:
- Reset (resetn=0 at a clk edge): FSM goes to IDLE, cnt=0, read-data register=0, latched address/op=0; stalled=0 and d_loadresult=0 afterwards. Memory contents are not cleared. A reset during WAIT aborts the load.
- misaligned is combinational and equals en & (half & a[0] | word & a[1:0]!=0 | dword & a[2:0]!=0).
- Store (en & op[3]):
  - Single cycle, no stall.
  - Write at the clk edge with byte enables derived from size and address low bits.
  - Suppressed if d_address[31]=1 or misaligned=1.
- Load FSM (states IDLE, WAIT, DONE):
  - IDLE & en & ~op[3]: stalled=1 combinationally; latch address low bits and op; cnt<=RD_LATENCY-1; go to WAIT. If RD_LATENCY=1, go directly to DONE.
  - WAIT: stalled=1; cnt decrements; at cnt=0 capture the memory word into the read register; go to DONE.
  - DONE: stalled=0; d_loadresult is valid this cycle; return to IDLE next edge. A new request is not accepted in DONE; the pipeline advances on this cycle.
  - Total stall for a load = RD_LATENCY cycles; data is valid on cycle RD_LATENCY+1 from the request.
  - en falling during WAIT: abort and go to IDLE next edge; stalled=0 once en=0.
  - Inputs are held stable by the pipeline while stalled=1.
- Load result:
  - Byte/half/word/dword selected from the read register by the latched address.
  - Extension to DM_DATAWIDTH uses sign when op[2]=1, zero otherwise.
  - A 32-bit word load on 64-bit memory also extends by op[2].
  - A misaligned load returns 0.
  - Loads from the I/O region read memory normally.
- Boot port: boot_dwe writes boot_ddata at boot_daddr at the clk edge. If it targets the same word as a same-cycle store, the boot write wins. Read-during-write on the same word returns new data.
- Unused upper address bits are ignored, so addresses wrap modulo DM_SIZE words.

Optional Feature:
DATA_MEM_PERF_EN:
- Adds output perf_stall_cycles (32-bit) and perf_loads (32-bit).
- perf_stall_cycles increments every cycle stalled=1; perf_loads increments on each DONE.
- Both counters clear on reset and saturate at all-ones.
- Without the macro, the ports and counters do not exist.

Test Plan:
- RD_LATENCY=3, DM_DATAWIDTH=32: SW 0xDEADBEEF at 0x10, then LW 0x10 -> stalled high exactly 3 cycles; cycle 4 d_loadresult=0xDEADBEEF.
- Bytes and halves: LB 0x11 -> 0xFFFFFFAD; LBU 0x11 -> 0x000000AD; LH 0x12 -> 0xFFFFBEEF; LHU 0x10 -> 0x0000DEAD.
- Alignment and I/O region: SH 0x13 -> misaligned=1, memory unchanged. SW 0x80000010 = 0x12345678 -> word 0x10 still 0xDEADBEEF. LW 0x12 -> misaligned=1, result 0.
- DM_DATAWIDTH=64: SD 0x0123456789ABCDEF at 0x8; LD 0x8 -> same value; LW 0xC -> 0xFFFFFFFF89ABCDEF; LWU (sign=0) 0xC -> 0x0000000089ABCDEF.
- Boot and reset: boot_dwe writes 0xCAFEF00D at word 4 while a store targets word 4 -> LW 0x10 returns 0xCAFEF00D. Assert resetn=0 during WAIT -> stalled=0 next cycle; a reissued load completes normally.
- DATA_MEM_PERF_EN with RD_LATENCY=2: 5 loads -> perf_loads=5, perf_stall_cycles=10; stores leave both unchanged.
